delay_watchdog: RTL and testbench

- Clocked watchdog/timeout generator that serves as the fallback retrigger path of the self-timed control block.
- Asserts `out` once both enabling inputs have been continuously true for a programmable number of clock cycles (for example, "retry pending" and "not done").
- After asserting, it re-arms so it keeps retriggering while the condition persists.
- Also provides busy status and a saturating count of fire events.

---
 rtl/delay_watchdog_if.sv | 29 ++
 rtl/delay_watchdog.sv | 155 +++++++++++++++
 tb/tb_delay_watchdog.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/delay_watchdog_if.sv
// Signal bundle for delay_watchdog: qualifying inputs, fire-count clear and status outputs.
interface delay_watchdog_if #(
  parameter int unsigned FIRE_W = 8
);
  logic              in1;
  logic              in2;
  logic              clear;
  logic              out;
  logic              busy;
  logic [FIRE_W-1:0] fire_cnt;

  modport master (
    output in1,
    output in2,
    output clear,
    input  out,
    input  busy,
    input  fire_cnt
  );

  modport slave (
    input  in1,
    input  in2,
    input  clear,
    output out,
    output busy,
    output fire_cnt
  );
endinterface

// File: rtl/delay_watchdog.sv
// Watchdog retrigger: fires a PULSE_LEN-cycle pulse after DELAY consecutive qualified cycles of
// in1 & in2, re-arming while the condition persists; keeps a saturating fire counter.
module delay_watchdog #(
  parameter int unsigned DELAY       = 6,
  parameter int unsigned PULSE_LEN   = 2,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FIRE_W      = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  delay_watchdog_if.slave bus
);

  localparam int unsigned       CNT_W        = 16;
  localparam logic [CNT_W-1:0]  DELAY_LAST   = CNT_W'(DELAY - 1);
  localparam logic [CNT_W-1:0]  PULSE_LAST   = CNT_W'(PULSE_LEN - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE      = CNT_W'(1);
  localparam logic [FIRE_W-1:0] FIRE_MAX     = {FIRE_W{1'b1}};
  localparam logic [FIRE_W-1:0] FIRE_ONE     = FIRE_W'(1);
  localparam bit                DELAY_IS_ONE = (DELAY == 32'd1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COUNT = 2'd1,
    ST_FIRE  = 2'd2
  } state_t;

  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_out;
  logic              r_busy;
  logic [FIRE_W-1:0] r_fire_cnt;

  logic w_in1_s;
  logic w_in2_s;
  logic w_cond;
  logic w_count_done;
  logic w_pulse_done;
  logic w_enter_fire;

  // Per-input synchroniser chains; SYNC_STAGES == 0 uses the inputs directly.
  generate
    if (SYNC_STAGES == 0) begin : g_direct
      assign w_in1_s = bus.in1;
      assign w_in2_s = bus.in2;
    end else begin : g_sync
      logic [SYNC_STAGES-1:0] r_sync1;
      logic [SYNC_STAGES-1:0] r_sync2;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_sync1 <= '0;
          r_sync2 <= '0;
        end else begin
          r_sync1 <= SYNC_STAGES'({r_sync1, bus.in1});
          r_sync2 <= SYNC_STAGES'({r_sync2, bus.in2});
        end
      end

      assign w_in1_s = r_sync1[SYNC_STAGES-1];
      assign w_in2_s = r_sync2[SYNC_STAGES-1];
    end
  endgenerate

  assign w_cond       = w_in1_s & w_in2_s;
  assign w_count_done = (r_cnt == DELAY_LAST);
  assign w_pulse_done = (r_cnt == PULSE_LAST);
  assign w_enter_fire = w_cond &
                        (((r_state == ST_IDLE) & DELAY_IS_ONE) |
                         ((r_state == ST_COUNT) & w_count_done));

  // The FIRE exit edge is not a qualified count edge, so re-arm spacing is DELAY+PULSE_LEN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_out   <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_cond && DELAY_IS_ONE) begin
            r_state <= ST_FIRE;
            r_cnt   <= '0;
            r_out   <= 1'b1;
            r_busy  <= 1'b1;
          end else if (w_cond) begin
            r_state <= ST_COUNT;
            r_cnt   <= CNT_ONE;
            r_out   <= 1'b0;
            r_busy  <= 1'b1;
          end else begin
            r_cnt   <= '0;
            r_out   <= 1'b0;
            r_busy  <= 1'b0;
          end
        end

        ST_COUNT: begin
          if (!w_cond) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_out   <= 1'b0;
            r_busy  <= 1'b0;
          end else if (w_count_done) begin
            r_state <= ST_FIRE;
            r_cnt   <= '0;
            r_out   <= 1'b1;
            r_busy  <= 1'b1;
          end else begin
            r_cnt   <= r_cnt + CNT_ONE;
            r_out   <= 1'b0;
            r_busy  <= 1'b1;
          end
        end

        ST_FIRE: begin
          if (w_pulse_done) begin
            r_state <= w_cond ? ST_COUNT : ST_IDLE;
            r_cnt   <= '0;
            r_out   <= 1'b0;
            r_busy  <= w_cond;
          end else begin
            r_cnt   <= r_cnt + CNT_ONE;
            r_out   <= 1'b1;
            r_busy  <= 1'b1;
          end
        end

        default: begin
          r_state <= ST_IDLE;
          r_cnt   <= '0;
          r_out   <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // Saturating fire counter; clear takes priority over a coincident fire entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fire_cnt <= '0;
    end else if (bus.clear) begin
      r_fire_cnt <= '0;
    end else if (w_enter_fire && (r_fire_cnt != FIRE_MAX)) begin
      r_fire_cnt <= r_fire_cnt + FIRE_ONE;
    end
  end

  assign bus.out      = r_out;
  assign bus.busy     = r_busy;
  assign bus.fire_cnt = r_fire_cnt;

endmodule

// File: tb/tb_delay_watchdog.sv
// Self-checking bench for delay_watchdog: three configurations against a cycle-level behavioural model.
module tb_delay_watchdog;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  delay_watchdog_if #(.FIRE_W(8)) if0 ();
  delay_watchdog_if #(.FIRE_W(2)) if1 ();
  delay_watchdog_if #(.FIRE_W(8)) if2 ();

  delay_watchdog #(.DELAY(6), .PULSE_LEN(2), .SYNC_STAGES(2), .FIRE_W(8)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .bus(if0.slave));
  delay_watchdog #(.DELAY(6), .PULSE_LEN(2), .SYNC_STAGES(2), .FIRE_W(2)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .bus(if1.slave));
  delay_watchdog #(.DELAY(1), .PULSE_LEN(1), .SYNC_STAGES(0), .FIRE_W(8)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .bus(if2.slave));

  // Model parameters and state, one slot per DUT.
  int       m_dly [3] = '{6, 6, 1};
  int       m_pl  [3] = '{2, 2, 1};
  int       m_ss  [3] = '{2, 2, 0};
  int       m_max [3] = '{255, 3, 255};
  int       m_streak [3];
  int       m_left   [3];
  int       m_fc     [3];
  bit       m_out    [3];
  bit       m_busy   [3];
  bit [2:0] m_h1     [3];
  bit [2:0] m_h2     [3];

  function automatic logic dut_out(int d);
    case (d)
      0:       return if0.out;
      1:       return if1.out;
      default: return if2.out;
    endcase
  endfunction

  function automatic logic dut_busy(int d);
    case (d)
      0:       return if0.busy;
      1:       return if1.busy;
      default: return if2.busy;
    endcase
  endfunction

  function automatic logic [7:0] dut_fc(int d);
    case (d)
      0:       return if0.fire_cnt;
      1:       return {6'b0, if1.fire_cnt};
      default: return if2.fire_cnt;
    endcase
  endfunction

  task automatic set_in(int d, logic a, logic b, logic c);
    case (d)
      0:       begin if0.in1 = a; if0.in2 = b; if0.clear = c; end
      1:       begin if1.in1 = a; if1.in2 = b; if1.clear = c; end
      default: begin if2.in1 = a; if2.in2 = b; if2.clear = c; end
    endcase
  endtask

  task automatic model_reset(int d);
    m_streak[d] = 0;
    m_left[d]   = 0;
    m_fc[d]     = 0;
    m_out[d]    = 1'b0;
    m_busy[d]   = 1'b0;
    m_h1[d]     = '0;
    m_h2[d]     = '0;
  endtask

  // One rising edge: cond is the input pair seen SYNC_STAGES edges earlier; count qualified
  // edges, fire on the DELAY-th, hold the pulse PULSE_LEN edges, then start counting afresh.
  task automatic model_step(int d, bit a, bit b, bit clr);
    bit c;
    bit fired;
    fired = 1'b0;
    if (m_ss[d] == 0) c = a & b;
    else              c = m_h1[d][m_ss[d]-1] & m_h2[d][m_ss[d]-1];
    m_h1[d] = {m_h1[d][1:0], a};
    m_h2[d] = {m_h2[d][1:0], b};
    if (m_left[d] > 0) begin
      m_left[d]--;
      if (m_left[d] == 0) begin
        m_out[d]    = 1'b0;
        m_busy[d]   = c;
        m_streak[d] = 0;
      end else begin
        m_out[d]  = 1'b1;
        m_busy[d] = 1'b1;
      end
    end else if (c) begin
      m_streak[d]++;
      m_busy[d] = 1'b1;
      if (m_streak[d] == m_dly[d]) begin
        fired       = 1'b1;
        m_left[d]   = m_pl[d];
        m_streak[d] = 0;
        m_out[d]    = 1'b1;
      end else begin
        m_out[d] = 1'b0;
      end
    end else begin
      m_streak[d] = 0;
      m_out[d]    = 1'b0;
      m_busy[d]   = 1'b0;
    end
    if (clr)                             m_fc[d] = 0;
    else if (fired && m_fc[d] < m_max[d]) m_fc[d]++;
  endtask

  task automatic tick();
    bit a [3];
    bit b [3];
    bit c [3];
    a[0] = if0.in1; b[0] = if0.in2; c[0] = if0.clear;
    a[1] = if1.in1; b[1] = if1.in2; c[1] = if1.clear;
    a[2] = if2.in1; b[2] = if2.in2; c[2] = if2.clear;
    @(posedge clk);
    for (int d = 0; d < 3; d++) begin
      if (!rst_n) model_reset(d);
      else        model_step(d, a[d], b[d], c[d]);
    end
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    for (int d = 0; d < 3; d++) begin
      set_in(d, 1'b0, 1'b0, 1'b0);
      model_reset(d);
    end
    repeat (2) tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    for (int d = 0; d < 3; d++) begin
      total++; if (dut_out(d) !== 1'b0) begin bad++; $display("FAIL reset_out d%0d got=%0b exp=0", d, dut_out(d)); end
      total++; if (dut_busy(d) !== 1'b0) begin bad++; $display("FAIL reset_busy d%0d got=%0b exp=0", d, dut_busy(d)); end
      total++; if (dut_fc(d) !== 8'd0) begin bad++; $display("FAIL reset_fc d%0d got=%0d exp=0", d, dut_fc(d)); end
    end
    // Reset in the middle of a count.
    set_in(0, 1'b1, 1'b1, 1'b0);
    repeat (4) tick();
    total++; if (dut_busy(0) !== 1'b1) begin bad++; $display("FAIL midcount_busy got=%0b exp=1", dut_busy(0)); end
    #2 rst_n = 1'b0;
    #1;
    total++; if (dut_busy(0) !== 1'b0) begin bad++; $display("FAIL rst_count_busy got=%0b exp=0", dut_busy(0)); end
    total++; if (dut_out(0) !== 1'b0) begin bad++; $display("FAIL rst_count_out got=%0b exp=0", dut_out(0)); end
    for (int d = 0; d < 3; d++) model_reset(d);
    repeat (2) tick();
    rst_n = 1'b1;
    // Reset in the middle of a pulse.
    for (int i = 0; i < 20 && !m_out[0]; i++) tick();
    total++; if (dut_out(0) !== 1'b1) begin bad++; $display("FAIL reach_fire got=%0b exp=1", dut_out(0)); end
    total++; if (dut_fc(0) !== 8'd1) begin bad++; $display("FAIL reach_fire_fc got=%0d exp=1", dut_fc(0)); end
    #2 rst_n = 1'b0;
    #1;
    total++; if (dut_out(0) !== 1'b0) begin bad++; $display("FAIL rst_fire_out got=%0b exp=0", dut_out(0)); end
    total++; if (dut_busy(0) !== 1'b0) begin bad++; $display("FAIL rst_fire_busy got=%0b exp=0", dut_busy(0)); end
    total++; if (dut_fc(0) !== 8'd0) begin bad++; $display("FAIL rst_fire_fc got=%0d exp=0", dut_fc(0)); end
    for (int d = 0; d < 3; d++) model_reset(d);
    set_in(0, 1'b0, 1'b0, 1'b0);
    repeat (2) tick();
    rst_n = 1'b1;
    for (int e = 1; e <= 20; e++) begin
      tick();
      total++; if (dut_out(0) !== 1'b0) begin bad++; $display("FAIL post_rst_out e=%0d got=%0b exp=0", e, dut_out(0)); end
    end
  endtask

  task automatic test_nominal();
    logic exp_out;
    apply_reset();
    set_in(0, 1'b1, 1'b1, 1'b0);
    for (int e = 1; e <= 12; e++) begin
      tick();
      exp_out = (e == 8) || (e == 9);
      total++; if (dut_out(0) !== exp_out) begin bad++; $display("FAIL nominal_out e=%0d got=%0b exp=%0b", e, dut_out(0), exp_out); end
      total++; if (dut_busy(0) !== m_busy[0]) begin bad++; $display("FAIL nominal_busy e=%0d got=%0b exp=%0b", e, dut_busy(0), m_busy[0]); end
      total++; if (dut_fc(0) !== 8'(m_fc[0])) begin bad++; $display("FAIL nominal_fc e=%0d got=%0d exp=%0d", e, dut_fc(0), m_fc[0]); end
    end
    total++; if (dut_fc(0) !== 8'd1) begin bad++; $display("FAIL nominal_fc_final got=%0d exp=1", dut_fc(0)); end
  endtask

  task automatic test_abort();
    int first_rise;
    first_rise = 0;
    apply_reset();
    for (int e = 1; e <= 20; e++) begin
      set_in(0, 1'b1, (e != 6), 1'b0);
      tick();
      if (dut_out(0) === 1'b1 && first_rise == 0) first_rise = e;
      total++; if (dut_out(0) !== m_out[0]) begin bad++; $display("FAIL abort_out e=%0d got=%0b exp=%0b", e, dut_out(0), m_out[0]); end
      total++; if (dut_busy(0) !== m_busy[0]) begin bad++; $display("FAIL abort_busy e=%0d got=%0b exp=%0b", e, dut_busy(0), m_busy[0]); end
    end
    total++; if (first_rise != 14) begin bad++; $display("FAIL abort_first_rise got=%0d exp=14", first_rise); end
  endtask

  task automatic test_single_input();
    apply_reset();
    set_in(0, 1'b1, 1'b0, 1'b0);
    for (int e = 1; e <= 100; e++) begin
      tick();
      total++; if (dut_out(0) !== 1'b0) begin bad++; $display("FAIL single_out e=%0d got=%0b exp=0", e, dut_out(0)); end
      total++; if (dut_busy(0) !== 1'b0) begin bad++; $display("FAIL single_busy e=%0d got=%0b exp=0", e, dut_busy(0)); end
    end
  endtask

  task automatic test_rearm_sat();
    logic prev;
    int   n_rise;
    int   last_rise;
    int   exp_fc;
    n_rise    = 0;
    last_rise = 0;
    apply_reset();
    set_in(1, 1'b1, 1'b1, 1'b0);
    prev = 1'b0;
    for (int e = 1; e <= 40; e++) begin
      tick();
      total++; if (dut_out(1) !== m_out[1]) begin bad++; $display("FAIL rearm_out e=%0d got=%0b exp=%0b", e, dut_out(1), m_out[1]); end
      if (prev === 1'b0 && dut_out(1) === 1'b1) begin
        n_rise++;
        if (n_rise > 1) begin
          total++; if (e - last_rise != 8) begin bad++; $display("FAIL rearm_period e=%0d got=%0d exp=8", e, e - last_rise); end
        end
        last_rise = e;
        exp_fc = (n_rise > 3) ? 3 : n_rise;
        total++; if (dut_fc(1) !== 8'(exp_fc)) begin bad++; $display("FAIL rearm_fc rise=%0d got=%0d exp=%0d", n_rise, dut_fc(1), exp_fc); end
      end
      prev = dut_out(1);
    end
    total++; if (n_rise != 5) begin bad++; $display("FAIL rearm_rises got=%0d exp=5", n_rise); end
    repeat (7) tick();
    set_in(1, 1'b1, 1'b1, 1'b1);
    tick();
    total++; if (dut_out(1) !== 1'b1) begin bad++; $display("FAIL clear_coinc_out got=%0b exp=1", dut_out(1)); end
    total++; if (dut_fc(1) !== 8'd0) begin bad++; $display("FAIL clear_coinc_fc got=%0d exp=0", dut_fc(1)); end
    set_in(1, 1'b1, 1'b1, 1'b0);
    repeat (8) tick();
    total++; if (dut_fc(1) !== 8'd1) begin bad++; $display("FAIL after_clear_fc got=%0d exp=1", dut_fc(1)); end
  endtask

  task automatic test_boundary();
    logic exp_out;
    apply_reset();
    set_in(2, 1'b1, 1'b1, 1'b0);
    for (int e = 1; e <= 6; e++) begin
      tick();
      exp_out = (e % 2 == 1);
      total++; if (dut_out(2) !== exp_out) begin bad++; $display("FAIL boundary_out e=%0d got=%0b exp=%0b", e, dut_out(2), exp_out); end
      total++; if (dut_fc(2) !== 8'(m_fc[2])) begin bad++; $display("FAIL boundary_fc e=%0d got=%0d exp=%0d", e, dut_fc(2), m_fc[2]); end
    end
  endtask

  task automatic test_random();
    apply_reset();
    for (int e = 1; e <= 400; e++) begin
      for (int d = 0; d < 3; d++)
        set_in(d, ($urandom_range(0, 7) != 0), ($urandom_range(0, 7) != 0), ($urandom_range(0, 29) == 0));
      tick();
      for (int d = 0; d < 3; d++) begin
        total++; if (dut_out(d) !== m_out[d]) begin bad++; $display("FAIL rand_out d%0d e=%0d got=%0b exp=%0b", d, e, dut_out(d), m_out[d]); end
        total++; if (dut_busy(d) !== m_busy[d]) begin bad++; $display("FAIL rand_busy d%0d e=%0d got=%0b exp=%0b", d, e, dut_busy(d), m_busy[d]); end
        total++; if (dut_fc(d) !== 8'(m_fc[d])) begin bad++; $display("FAIL rand_fc d%0d e=%0d got=%0d exp=%0d", d, e, dut_fc(d), m_fc[d]); end
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    for (int d = 0; d < 3; d++) set_in(d, 1'b0, 1'b0, 1'b0);
    apply_reset();
    test_reset();
    test_nominal();
    test_abort();
    test_single_input();
    test_rearm_sat();
    test_boundary();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
